idex_stage: RTL and testbench



---
 rtl/idex_stage.sv | 180 ++++++++++++++++++
 tb/tb_idex_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : idex_stage
//  Purpose  : ID/EX pipeline register of the 5-stage RV32I core. Captures the
//             decode-stage control and operand data every clock and presents
//             it to execute. Detects load-use hazards and inserts a bubble for
//             them, inserts a bubble on a taken-branch flush, and freezes
//             completely while the memory stage holds the pipeline.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i            rising-edge clock
//    rst_i            synchronous, active-high reset
//    hold_i           global freeze (memory stall), highest non-reset priority
//    flush_i          taken branch/jump resolved in EX, kills the entering op
//    valid_d_i        decode slot holds a real instruction
//    *_d_i            decode control, data and register indices
//    *_e_o            registered copies of every *_d_i (control masked when
//                     valid_e_o is low)
//    lduse_stall_o    combinational load-use stall, freezes PC and IF/ID
//    bubble_cnt_o     saturating count of inserted bubbles
//  Configuration
//    IDEX_PERF_EN     when defined, bubble_cnt_o counts bubbles; otherwise it
//                     is tied to zero and no counter register exists.
// ============================================================================
module idex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            valid_d_i,
  input  logic            regwrite_d_i,
  input  logic            memwrite_d_i,
  input  logic            jump_d_i,
  input  logic            branch_d_i,
  input  logic            alusrc_d_i,
  input  logic [1:0]      resultsrc_d_i,
  input  logic [2:0]      alucontrol_d_i,
  input  logic [XLEN-1:0] rd1_d_i,
  input  logic [XLEN-1:0] rd2_d_i,
  input  logic [XLEN-1:0] pc_d_i,
  input  logic [XLEN-1:0] immext_d_i,
  input  logic [XLEN-1:0] pcplus4_d_i,
  input  logic [4:0]      rs1_d_i,
  input  logic [4:0]      rs2_d_i,
  input  logic [4:0]      rd_d_i,
  output logic            valid_e_o,
  output logic            regwrite_e_o,
  output logic            memwrite_e_o,
  output logic            jump_e_o,
  output logic            branch_e_o,
  output logic            alusrc_e_o,
  output logic [1:0]      resultsrc_e_o,
  output logic [2:0]      alucontrol_e_o,
  output logic [XLEN-1:0] rd1_e_o,
  output logic [XLEN-1:0] rd2_e_o,
  output logic [XLEN-1:0] pc_e_o,
  output logic [XLEN-1:0] immext_e_o,
  output logic [XLEN-1:0] pcplus4_e_o,
  output logic [4:0]      rs1_e_o,
  output logic [4:0]      rs2_e_o,
  output logic [4:0]      rd_e_o,
  output logic            lduse_stall_o,
  output logic [31:0]     bubble_cnt_o
);

  localparam logic [1:0] C_RESULT_LOAD = 2'b01;

  logic            r_valid;
  logic            r_regwrite;
  logic            r_memwrite;
  logic            r_jump;
  logic            r_branch;
  logic            r_alusrc;
  logic [1:0]      r_resultsrc;
  logic [2:0]      r_alucontrol;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_immext;
  logic [XLEN-1:0] r_pcplus4;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;

  logic            w_lduse;
  logic            w_bubble;

  // Control captured from an invalid decode slot is kept as-is in the
  // registers; gating with valid here guarantees an invalid slot can never
  // write registers or memory, and keeps the hazard check below honest.
  assign valid_e_o      = r_valid;
  assign regwrite_e_o   = r_valid & r_regwrite;
  assign memwrite_e_o   = r_valid & r_memwrite;
  assign jump_e_o       = r_valid & r_jump;
  assign branch_e_o     = r_valid & r_branch;
  assign alusrc_e_o     = r_valid & r_alusrc;
  assign resultsrc_e_o  = r_valid ? r_resultsrc  : 2'b00;
  assign alucontrol_e_o = r_valid ? r_alucontrol : 3'b000;
  assign rd1_e_o        = r_rd1;
  assign rd2_e_o        = r_rd2;
  assign pc_e_o         = r_pc;
  assign immext_e_o     = r_immext;
  assign pcplus4_e_o    = r_pcplus4;
  assign rs1_e_o        = r_rs1;
  assign rs2_e_o        = r_rs2;
  assign rd_e_o         = r_rd;

  // A load in EX whose destination is a source of the decode instruction.
  // Suppressed under hold (nothing moves anyway) and under flush (the decode
  // instruction is being killed, and the fetch redirect must not be frozen).
  assign w_lduse = valid_e_o
                 & (resultsrc_e_o == C_RESULT_LOAD)
                 & (rd_e_o != 5'd0)
                 & valid_d_i
                 & ((rd_e_o == rs1_d_i) | (rd_e_o == rs2_d_i))
                 & ~hold_i
                 & ~flush_i;

  assign lduse_stall_o = w_lduse;
  assign w_bubble      = flush_i | w_lduse;

  always_ff @(posedge clk_i) begin
    if (rst_i || (!hold_i && w_bubble)) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_alusrc     <= 1'b0;
      r_resultsrc  <= 2'b00;
      r_alucontrol <= 3'b000;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_pc         <= '0;
      r_immext     <= '0;
      r_pcplus4    <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
    end else if (!hold_i) begin
      r_valid      <= valid_d_i;
      r_regwrite   <= regwrite_d_i;
      r_memwrite   <= memwrite_d_i;
      r_jump       <= jump_d_i;
      r_branch     <= branch_d_i;
      r_alusrc     <= alusrc_d_i;
      r_resultsrc  <= resultsrc_d_i;
      r_alucontrol <= alucontrol_d_i;
      r_rd1        <= rd1_d_i;
      r_rd2        <= rd2_d_i;
      r_pc         <= pc_d_i;
      r_immext     <= immext_d_i;
      r_pcplus4    <= pcplus4_d_i;
      r_rs1        <= rs1_d_i;
      r_rs2        <= rs2_d_i;
      r_rd         <= rd_d_i;
    end
  end

`ifdef IDEX_PERF_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= 32'h0;
    end else if (!hold_i && w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`else
  assign bubble_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idex_stage
//  Purpose  : Self-checking bench for idex_stage. A driver applies directed
//             rows and queues the hand-computed expected observation; a
//             monitor pops and compares at the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idex_stage;

  localparam int XLEN = 32;

  // {regwrite, memwrite, jump, branch, alusrc, resultsrc[1:0], alucontrol[2:0]}
  localparam logic [9:0] C_LW  = 10'b1000101000;
  localparam logic [9:0] C_OR  = 10'b1000000110;
  localparam logic [9:0] C_SW  = 10'b0100100000;
  localparam logic [9:0] C_BEQ = 10'b0001000001;

  logic            clk = 1'b0;
  logic            rst, hold, flush, valid_d;
  logic            regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
  logic [1:0]      resultsrc_d;
  logic [2:0]      alucontrol_d;
  logic [XLEN-1:0] rd1_d, rd2_d, pc_d, immext_d, pcplus4_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            valid_e, regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e;
  logic [1:0]      resultsrc_e;
  logic [2:0]      alucontrol_e;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, immext_e, pcplus4_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic            lduse;
  logic [31:0]     bubble_cnt;

  idex_stage #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .valid_d_i(valid_d), .regwrite_d_i(regwrite_d), .memwrite_d_i(memwrite_d),
    .jump_d_i(jump_d), .branch_d_i(branch_d), .alusrc_d_i(alusrc_d),
    .resultsrc_d_i(resultsrc_d), .alucontrol_d_i(alucontrol_d),
    .rd1_d_i(rd1_d), .rd2_d_i(rd2_d), .pc_d_i(pc_d), .immext_d_i(immext_d),
    .pcplus4_d_i(pcplus4_d), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rd_d_i(rd_d),
    .valid_e_o(valid_e), .regwrite_e_o(regwrite_e), .memwrite_e_o(memwrite_e),
    .jump_e_o(jump_e), .branch_e_o(branch_e), .alusrc_e_o(alusrc_e),
    .resultsrc_e_o(resultsrc_e), .alucontrol_e_o(alucontrol_e),
    .rd1_e_o(rd1_e), .rd2_e_o(rd2_e), .pc_e_o(pc_e), .immext_e_o(immext_e),
    .pcplus4_e_o(pcplus4_e), .rs1_e_o(rs1_e), .rs2_e_o(rs2_e), .rd_e_o(rd_e),
    .lduse_stall_o(lduse), .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [9:0]  ectl;
    logic [4:0]  es1, es2, ed;
    logic [31:0] etag;
    logic        el;
    logic [31:0] ecnt;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row_id = 0;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL row%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Data fields are derived from a tag so that tag 0 means all-zero data.
  task automatic row(input logic r, h, f, v, input logic [9:0] ctl,
                     input logic [4:0] s1, s2, d, input int tag, input logic chk,
                     input logic ev, input logic [9:0] ectl,
                     input logic [4:0] es1, es2, ed, input int etag,
                     input logic el, input logic [31:0] ecnt_perf);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hold = h; flush = f; valid_d = v;
    {regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d, resultsrc_d, alucontrol_d} = ctl;
    rs1_d = s1; rs2_d = s2; rd_d = d;
    rd1_d = tag; rd2_d = tag * 3; pc_d = tag * 4; immext_d = tag * 5; pcplus4_d = tag * 6;
    if (chk) begin
      e.ev = ev; e.ectl = ectl; e.es1 = es1; e.es2 = es2; e.ed = ed;
      e.etag = etag; e.el = el; e.id = row_id;
`ifdef IDEX_PERF_EN
      e.ecnt = ecnt_perf;
`else
      e.ecnt = 32'h0;
`endif
      q.push_back(e);
    end
    row_id++;
  endtask

  // Monitor: compares the mid-cycle observation against the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("valid_e", e.id, {31'h0, valid_e}, {31'h0, e.ev});
        check("ctl_e", e.id,
              {22'h0, regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, resultsrc_e, alucontrol_e},
              {22'h0, e.ectl});
        check("rs1_e", e.id, {27'h0, rs1_e}, {27'h0, e.es1});
        check("rs2_e", e.id, {27'h0, rs2_e}, {27'h0, e.es2});
        check("rd_e", e.id, {27'h0, rd_e}, {27'h0, e.ed});
        check("rd1_e", e.id, rd1_e, e.etag);
        check("rd2_e", e.id, rd2_e, e.etag * 3);
        check("pc_e", e.id, pc_e, e.etag * 4);
        check("immext_e", e.id, immext_e, e.etag * 5);
        check("pcplus4_e", e.id, pcplus4_e, e.etag * 6);
        check("lduse_stall", e.id, {31'h0, lduse}, {31'h0, e.el});
        check("bubble_cnt", e.id, bubble_cnt, e.ecnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected end", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; valid_d = 1'b0;
    {regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d, resultsrc_d, alucontrol_d} = 10'h0;
    rd1_d = '0; rd2_d = '0; pc_d = '0; immext_d = '0; pcplus4_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;

    //   rst hold flsh vld  ctl   s1 s2 d  tag chk | ev  ectl  es1 es2 ed etag el cnt
    // reset for two cycles with non-zero inputs
    row(1, 0, 0, 1, C_OR,  1, 2, 3,  9, 0,  0, 10'h0, 0, 0, 0,  0, 0, 0);
    row(1, 0, 0, 1, C_OR,  1, 2, 3,  9, 1,  0, 10'h0, 0, 0, 0,  0, 0, 0);
    // pass-through, then lw x5 followed by a dependent op (rs2 = 5)
    row(0, 0, 0, 1, C_OR,  1, 2, 7,  5, 1,  0, 10'h0, 0, 0, 0,  0, 0, 0);
    row(0, 0, 0, 1, C_LW,  2, 0, 5, 10, 1,  1, C_OR,  1, 2, 7,  5, 0, 0);
    row(0, 0, 0, 1, C_OR,  6, 5, 8, 11, 1,  1, C_LW,  2, 0, 5, 10, 1, 0);
    row(0, 0, 0, 1, C_OR,  6, 5, 8, 11, 1,  0, 10'h0, 0, 0, 0,  0, 0, 1);
    // lw x0 followed by an op reading x0: no stall
    row(0, 0, 0, 1, C_LW,  1, 0, 0, 12, 1,  1, C_OR,  6, 5, 8, 11, 0, 1);
    row(0, 0, 0, 1, C_OR,  0, 0, 9, 13, 1,  1, C_LW,  1, 0, 0, 12, 0, 1);
    // flush coinciding with a load-use hazard: one bubble, stall suppressed
    row(0, 0, 0, 1, C_LW,  3, 0, 5, 14, 1,  1, C_OR,  0, 0, 9, 13, 0, 1);
    row(0, 0, 1, 1, C_OR,  5, 4,10, 15, 1,  1, C_LW,  3, 0, 5, 14, 0, 1);
    // hold for three cycles with flush high and changing inputs, then release
    row(0, 0, 0, 1, C_SW,  1, 2, 0, 16, 1,  0, 10'h0, 0, 0, 0,  0, 0, 2);
    row(0, 1, 1, 1, C_BEQ, 3, 4, 0, 17, 1,  1, C_SW,  1, 2, 0, 16, 0, 2);
    row(0, 1, 1, 1, C_LW,  1, 1, 6, 18, 1,  1, C_SW,  1, 2, 0, 16, 0, 2);
    row(0, 1, 1, 0, C_OR,  2, 2, 7, 19, 1,  1, C_SW,  1, 2, 0, 16, 0, 2);
    row(0, 0, 1, 1, C_OR,  1, 2, 3, 20, 1,  1, C_SW,  1, 2, 0, 16, 0, 2);
    // invalid slot: data captured, control masked, no false load-use
    row(0, 0, 0, 0, C_LW,  4, 5, 6, 21, 1,  0, 10'h0, 0, 0, 0,  0, 0, 3);
    row(0, 0, 0, 1, C_OR,  6, 0, 1, 22, 1,  0, 10'h0, 4, 5, 6, 21, 0, 3);
    // reset asserted while a load-use stall is active
    row(0, 0, 0, 1, C_LW,  0, 0, 3, 23, 1,  1, C_OR,  6, 0, 1, 22, 0, 3);
    row(1, 0, 0, 1, C_OR,  3, 0, 4, 24, 1,  1, C_LW,  0, 0, 3, 23, 1, 3);
    row(0, 0, 0, 1, C_OR,  3, 0, 4, 24, 1,  0, 10'h0, 0, 0, 0,  0, 0, 0);
    // reset asserted while hold is active
    row(0, 0, 0, 0, 10'h0, 0, 0, 0,  0, 1,  1, C_OR,  3, 0, 4, 24, 0, 0);
    row(0, 0, 0, 1, C_SW,  1, 2, 0, 26, 1,  0, 10'h0, 0, 0, 0,  0, 0, 0);
    row(1, 1, 0, 1, C_OR,  1, 2, 3, 25, 1,  1, C_SW,  1, 2, 0, 26, 0, 0);
    row(0, 0, 0, 0, 10'h0, 0, 0, 0,  0, 1,  0, 10'h0, 0, 0, 0,  0, 0, 0);

`ifdef IDEX_PERF_EN
    // counter saturation: preload near the top, then three flush bubbles
    @(posedge clk);
    #1;
    dut.r_bubble_cnt = 32'hFFFF_FFFE;
    row(0, 0, 1, 1, C_OR,  1, 2, 3, 27, 1,  0, 10'h0, 0, 0, 0,  0, 0, 32'hFFFF_FFFE);
    row(0, 0, 1, 1, C_OR,  1, 2, 3, 27, 1,  0, 10'h0, 0, 0, 0,  0, 0, 32'hFFFF_FFFF);
    row(0, 0, 1, 1, C_OR,  1, 2, 3, 27, 1,  0, 10'h0, 0, 0, 0,  0, 0, 32'hFFFF_FFFF);
    row(0, 0, 0, 0, 10'h0, 0, 0, 0,  0, 1,  0, 10'h0, 0, 0, 0,  0, 0, 32'hFFFF_FFFF);
`endif

    repeat (2) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
